switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//  Multi-channel input conditioner for slide switches and keys (SW1..SW4 and up).
//  Synchronises each raw pad input to sys_clk, then debounces it.
//  Emits a clean level plus one-cycle rise/fall strobes per channel.
//  Sits between the board pins and every logic/LED block that consumes switch levels.
// PARAMETERS
//  CH           4           number of independent channels
//  CLK_FREQ_HZ  50_000_000  sys_clk frequency
//  DEBOUNCE_MS  20          required stable time; CNT_MAX = CLK_FREQ_HZ/1000*DEBOUNCE_MS; must be >= 2
// PORTS
//  sys_clk    in   1   single system clock; all logic on rising edge
//  sys_rst_n  in   1   reset, synchronous, active-low
//  sw_in      in   CH  raw asynchronous switch/key pins (1 = switch on)
//  sw_level   out  CH  debounced level, registered
//  sw_rise    out  CH  1-cycle strobe when sw_level goes 0->1
//  sw_fall    out  CH  1-cycle strobe when sw_level goes 1->0
// BEHAVIOUR
//  - Reset: sampled on the sys_clk edge while sys_rst_n=0. Clears sync flops, counters, FSM (IDLE), sw_level,
//    sw_rise and sw_fall to 0. Reset mid-check discards the partial count.
//  - Sync: two flops per channel (s1, s2). Only s2 feeds the FSM; sw_in is never used directly.
//  - Per-channel FSM, two states:
//    IDLE:  s2 == sw_level -> stay, cnt=0.
//           s2 != sw_level -> CHECK, cnt=1.
//    CHECK: s2 == sw_level (bounce) -> IDLE, cnt=0, no output change.
//           s2 != sw_level, cnt < CNT_MAX-1 -> cnt++.
//           s2 != sw_level, cnt == CNT_MAX-1 -> sw_level <= s2, strobe, IDLE, cnt=0.
//  - Latency: sw_in changes before edge 1 and holds. sw_level and the strobe update on edge CNT_MAX+2.
//  - Strobes: sw_rise[i]/sw_fall[i] are high for exactly the one cycle after sw_level[i] changes. Never both high.
//    Both are 0 on all other cycles.
//  - Counter width: $clog2(CNT_MAX). The counter saturates by construction and never wraps.
//  - Channels are fully independent. Simultaneous transitions on any subset are each handled on their own timeline.
//  - Switch held on through reset release: sw_level rises CNT_MAX+2 edges after release, with one sw_rise strobe.
//  - Glitch shorter than CNT_MAX consecutive s2 samples: no change on any output.
// STRUCTURE
//  - Package board_io_pkg:
//    - debounce state enum {DB_IDLE, DB_CHECK}
//    - function db_cnt_max(clk_hz, ms)
//    - localparam DEFAULT_CLK_FREQ_HZ = 50_000_000
//  - Sub-module debounce_ch: one channel (sync pair, FSM, counter, level and strobe registers).
//  - Top: generate loop over CH instances. No shared state between channels.
// TESTING  (bench: CLK_FREQ_HZ=1000, DEBOUNCE_MS=8 -> CNT_MAX=8, CH=4)
//  1. Reset with sw_in=4'hF, hold, release:
//     sw_level=0 until edge 10 after release, then 4'hF; sw_rise=4'hF for 1 cycle.
//  2. sw_in[0] 0->1 held clean:
//     sw_level[0] rises on edge 10; sw_rise[0] high 1 cycle; sw_fall, other channels stay 0.
//  3. sw_in[1] bounces 1,0,1,0 at 3-cycle spacing, then holds 1:
//     no output change during bounce; sw_level[1]=1 exactly 10 edges after last toggle.
//  4. sw_in goes 0->4'b1010 and, 4 cycles later, 4'b1010->4'b1011:
//     ch1,ch3 rise on edge 10; ch0 rises on edge 14.
//  5. sw_in[2] stable 1, then 1->0 and reassert sys_rst_n=0 on cycle 5 of CHECK:
//     sw_level=0, no sw_fall strobe; after release with sw_in[2]=0, level stays 0.
//  6. 1-cycle glitch on all channels every 5 cycles for 200 cycles:
//     sw_level, sw_rise, sw_fall remain 0 throughout.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the board I/O conditioning blocks.
//   DB_IDLE / DB_CHECK : per-channel debounce FSM states
//   db_cnt_max()        : stable-time length in sys_clk cycles
//   DEFAULT_CLK_FREQ_HZ : nominal system clock frequency
package board_io_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 50_000_000;

  typedef enum logic {
    DB_IDLE,
    DB_CHECK
  } db_state_e;

  // Number of consecutive stable samples required before a level change
  // is accepted. Callers must keep the result >= 2.
  function automatic int unsigned db_cnt_max(input int unsigned clk_hz,
                                             input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle between the board pins and the debounce block.
//   sw_in    : raw asynchronous pad levels (1 = switch on)
//   sw_level : debounced level per channel
//   sw_rise  : one-cycle strobe on a debounced 0->1 change
//   sw_fall  : one-cycle strobe on a debounced 1->0 change
// master drives sw_in and consumes the conditioned outputs; slave is the
// debounce block itself.
interface switch_debounce_if #(
  parameter int unsigned CH = 4
);

  logic [CH-1:0] sw_in;
  logic [CH-1:0] sw_level;
  logic [CH-1:0] sw_rise;
  logic [CH-1:0] sw_fall;

  modport master (
    output sw_in,
    input  sw_level,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_in,
    output sw_level,
    output sw_rise,
    output sw_fall
  );

endinterface

// File: rtl/switch_debounce_ch.sv
// One debounce channel: two-flop synchroniser, IDLE/CHECK FSM with a
// stable-time counter, registered level and rise/fall strobes.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   sw_in     : raw asynchronous pin
//   sw_level  : debounced level
//   sw_rise   : one-cycle strobe after sw_level goes 0->1
//   sw_fall   : one-cycle strobe after sw_level goes 1->0
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int unsigned CNT_MAX = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic sw_in,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned     CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    s1_d    = sw_in;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      DB_IDLE: begin
        if (s2_q != level_q) begin
          state_d = DB_CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      DB_CHECK: begin
        if (s2_q == level_q) begin
          // Bounce back to the current level: drop the partial count.
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          // cnt_q < CNT_LAST here, so the increment cannot wrap.
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch/key input conditioner. Each channel is synchronised
// to sys_clk and debounced independently; no state is shared.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   sw_bus    : slave side of switch_debounce_if
//               (sw_in in; sw_level, sw_rise, sw_fall out)
// Parameters: CH channels, CLK_FREQ_HZ clock rate, DEBOUNCE_MS stable time.
module switch_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  switch_debounce_if.slave  sw_bus
);

  localparam int unsigned CNT_MAX = db_cnt_max(CLK_FREQ_HZ, DEBOUNCE_MS);

  logic [CH-1:0] level_w;
  logic [CH-1:0] rise_w;
  logic [CH-1:0] fall_w;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .sw_in     (sw_bus.sw_in[i]),
      .sw_level  (level_w[i]),
      .sw_rise   (rise_w[i]),
      .sw_fall   (fall_w[i])
    );
  end

  assign sw_bus.sw_level = level_w;
  assign sw_bus.sw_rise  = rise_w;
  assign sw_bus.sw_fall  = fall_w;

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (CH=4, CNT_MAX=8).
module tb_switch_debounce;

  localparam int unsigned CH      = 4;
  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned DB_MS   = 8;
  localparam int unsigned CNT_MAX = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  switch_debounce_if #(.CH(CH)) sw_bus ();

  switch_debounce #(
    .CH          (CH),
    .CLK_FREQ_HZ (CLK_HZ),
    .DEBOUNCE_MS (DB_MS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sw_bus    (sw_bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last CNT_MAX synchronised
  // samples taken since the previous flip all disagree with it. The
  // synchronised sample is the pin value seen two edges earlier.
  logic [3:0] m_level = '0, m_rise = '0, m_fall = '0;
  logic [3:0] m_dly1 = '0, m_dly2 = '0;
  logic       hist[CH][$];
  bit         model_on = 1'b0;

  always @(posedge sys_clk) begin : model
    logic [3:0] smp;
    bit         all_diff;
    if (!sys_rst_n) begin
      m_level = '0; m_rise = '0; m_fall = '0;
      m_dly1  = '0; m_dly2 = '0;
      for (int c = 0; c < CH; c++) hist[c].delete();
    end else begin
      smp    = m_dly2;
      m_dly2 = m_dly1;
      m_dly1 = sw_bus.sw_in;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        hist[c].push_back(smp[c]);
        if (hist[c].size() > CNT_MAX) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == CNT_MAX);
        for (int k = 0; k < hist[c].size(); k++)
          if (hist[c][k] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_rise[c] = 1'b1;
          else            m_fall[c] = 1'b1;
          hist[c].delete();
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (model_on) begin
      check("model_level", sw_bus.sw_level, m_level);
      check("model_rise",  sw_bus.sw_rise,  m_rise);
      check("model_fall",  sw_bus.sw_fall,  m_fall);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input logic [3:0] val);
    sys_rst_n    = 1'b0;
    sw_bus.sw_in = val;
    tick(3);
    sys_rst_n    = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  sw;
    int unsigned hold;
    logic [3:0]  lvl;
    logic [3:0]  rise;
    logic [3:0]  fall;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tbl[0] = '{4'h5, 12, 4'h5, 4'h0, 4'h0};
    tbl[1] = '{4'hA, 12, 4'hA, 4'h0, 4'h0};
    tbl[2] = '{4'h0,  5, 4'hA, 4'h0, 4'h0};
    tbl[3] = '{4'h0,  7, 4'h0, 4'h0, 4'h0};
    tbl[4] = '{4'hF,  9, 4'h0, 4'h0, 4'h0};
    tbl[5] = '{4'hF,  1, 4'hF, 4'hF, 4'h0};
    tbl[6] = '{4'h0,  9, 4'hF, 4'h0, 4'h0};
    tbl[7] = '{4'h0,  1, 4'h0, 4'h0, 4'hF};

    // 1: switches held on through reset
    sys_rst_n    = 1'b0;
    sw_bus.sw_in = 4'hF;
    tick(1);
    model_on = 1'b1;
    tick(3);
    check("t1_reset_level", sw_bus.sw_level, 4'h0);
    check("t1_reset_rise",  sw_bus.sw_rise,  4'h0);
    check("t1_reset_fall",  sw_bus.sw_fall,  4'h0);
    sys_rst_n = 1'b1;
    tick(9);
    check("t1_edge9_level", sw_bus.sw_level, 4'h0);
    tick(1);
    check("t1_edge10_level", sw_bus.sw_level, 4'hF);
    check("t1_edge10_rise",  sw_bus.sw_rise,  4'hF);
    tick(1);
    check("t1_edge11_rise",  sw_bus.sw_rise,  4'h0);
    check("t1_edge11_level", sw_bus.sw_level, 4'hF);

    // 2: clean single-channel rise
    do_reset(4'h0);
    sw_bus.sw_in = 4'h1;
    tick(9);
    check("t2_edge9_level", sw_bus.sw_level, 4'h0);
    tick(1);
    check("t2_edge10_level", sw_bus.sw_level, 4'h1);
    check("t2_edge10_rise",  sw_bus.sw_rise,  4'h1);
    check("t2_edge10_fall",  sw_bus.sw_fall,  4'h0);
    tick(1);
    check("t2_edge11_rise",  sw_bus.sw_rise,  4'h0);

    // 3: bouncing channel 1
    do_reset(4'h0);
    for (int b = 0; b < 4; b++) begin
      sw_bus.sw_in[1] = (b % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check("t3_bounce_out", sw_bus.sw_level | sw_bus.sw_rise | sw_bus.sw_fall, 4'h0);
      end
    end
    sw_bus.sw_in[1] = 1'b1;
    tick(9);
    check("t3_edge9_level", sw_bus.sw_level, 4'h0);
    tick(1);
    check("t3_edge10_level", sw_bus.sw_level, 4'h2);
    check("t3_edge10_rise",  sw_bus.sw_rise,  4'h2);

    // 4: staggered multi-channel transitions
    do_reset(4'h0);
    sw_bus.sw_in = 4'hA;
    tick(4);
    sw_bus.sw_in = 4'hB;
    tick(5);
    check("t4_edge9_level", sw_bus.sw_level, 4'h0);
    tick(1);
    check("t4_edge10_level", sw_bus.sw_level, 4'hA);
    check("t4_edge10_rise",  sw_bus.sw_rise,  4'hA);
    tick(3);
    check("t4_edge13_level", sw_bus.sw_level, 4'hA);
    tick(1);
    check("t4_edge14_level", sw_bus.sw_level, 4'hB);
    check("t4_edge14_rise",  sw_bus.sw_rise,  4'h1);

    // 5: reset during CHECK discards the pending fall
    do_reset(4'h0);
    sw_bus.sw_in = 4'h4;
    tick(12);
    check("t5_setup_level", sw_bus.sw_level, 4'h4);
    sw_bus.sw_in = 4'h0;
    tick(6);
    check("t5_mid_level", sw_bus.sw_level, 4'h4);
    sys_rst_n = 1'b0;
    tick(1);
    check("t5_rst_level", sw_bus.sw_level, 4'h0);
    check("t5_rst_fall",  sw_bus.sw_fall,  4'h0);
    tick(1);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("t5_post_out", sw_bus.sw_level | sw_bus.sw_fall, 4'h0);
    end

    // 6: periodic 1-cycle glitches
    do_reset(4'h0);
    for (int k = 0; k < 200; k++) begin
      sw_bus.sw_in = (k % 5 == 0) ? 4'hF : 4'h0;
      tick(1);
      check("t6_quiet", sw_bus.sw_level | sw_bus.sw_rise | sw_bus.sw_fall, 4'h0);
    end

    // Table-driven boundary vectors
    do_reset(4'h0);
    for (int v = 0; v < 8; v++) begin
      sw_bus.sw_in = tbl[v].sw;
      tick(tbl[v].hold);
      check($sformatf("tbl%0d_level", v), sw_bus.sw_level, tbl[v].lvl);
      check($sformatf("tbl%0d_rise",  v), sw_bus.sw_rise,  tbl[v].rise);
      check($sformatf("tbl%0d_fall",  v), sw_bus.sw_fall,  tbl[v].fall);
    end

    // Random segments, checked against the model every cycle
    do_reset(4'h0);
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        sys_rst_n = 1'b0;
        tick($urandom_range(1, 3));
        sys_rst_n = 1'b1;
      end
      sw_bus.sw_in = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 14));
    end

    tick(1);
    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
